spike_event_streamer: RTL and testbench
=======================================

// Module: spike_event_streamer
// PURPOSE
//  Multi-channel successor to the fixed one-word-per-read raw-spike pipe packers. Captures spikes from
//  NCH time-multiplexed neuron populations (Ia, II, MN, ...) as (channel, neuron index) event words.
//  Inserts a timestamp marker word on every sim-step tick and buffers all words in a show-ahead FIFO.
//  Drains that FIFO through an okBTPipeOut read strobe. Only real events are sent, not every neuron slot.
// PARAMETERS
//  NCH        3   spike channels, 1..16
//  NN         8   neuron index width is NN+1 bits, NN+1 <= 11
//  DEPTH_LOG2 10  FIFO depth = 2**DEPTH_LOG2 words
// PORTS
//  clk           in   1           single clock (neuron_clk domain); all logic on posedge
//  reset_n       in   1           asynchronous, active-low reset
//  clear         in   1           synchronous flush; same effect as reset
//  enable        in   1           0: no new words are captured or pushed; draining continues
//  tick          in   1           1-cycle pulse per sim step (sim_clk rising edge, pre-synchronised)
//  index_valid   in   1           1-cycle strobe: neuron_index and spike_in are valid (neuronWriteEnable)
//  neuron_index  in   NN+1        neuron currently being evaluated
//  spike_in      in   NCH         per-channel spike bits, sampled only when index_valid=1
//  pipe_read     in   1           pop strobe (ep_read)
//  pipe_dout     out  16          FIFO head word (ep_datain)
//  fifo_count    out  DEPTH_LOG2+1 words held
//  empty, full   out  1           FIFO flags
//  drop_cnt      out  16          saturating count of words lost
//  underflow     out  1           sticky: pipe_read seen while empty
// BEHAVIOUR
//  Reset and clear: FIFO emptied; pending cleared; ts=0; drop_cnt=0; underflow=0; pipe_dout=16'h0000.
//    Outputs after reset/clear: empty=1, full=0, fifo_count=0.
//  Word formats:
//    Event word = {1'b1, ch[3:0], 11'(neuron_index)}.
//    Tick word  = {1'b0, ts[14:0]}. ts is a 15-bit step counter that increments on each tick and wraps 7FFF->0000.
//  Capture, when index_valid=1 and enable=1:
//    For each c with spike_in[c]=1, pending[c] is set and idx[c] is latched.
//    If pending[c] is already set, the new event is dropped and drop_cnt increments.
//  Push arbitration, at most one push per cycle:
//    Priority 1: a pending tick word. A tick raises tick_pend; the word carries the ts value after increment.
//    Priority 2: pending[c], lowest c first.
//    A chosen slot clears in the same cycle as its push.
//  Latency: spike at index_valid in cycle N, no contention, FIFO empty -> word on pipe_dout and empty=0 in cycle N+2.
//  Full:
//    A push attempt while full=1 and pipe_read=0 discards the word, clears its slot, and increments drop_cnt.
//    With full=1 and pipe_read=1 in the same cycle, pop and push both take effect; count is unchanged.
//    drop_cnt saturates at 16'hFFFF.
//  Empty:
//    pipe_read while empty sets underflow, leaves the FIFO unchanged, and pipe_dout stays 16'h0000.
//    If a push and pipe_read coincide while empty, the read is still an underflow; the pushed word is kept.
//  Pop: pipe_read=1 and not empty -> head advances at the clock edge; the new head is valid in the next cycle.
//  Other conditions:
//    tick and index_valid in the same cycle: both are captured.
//    A second tick while tick_pend is still set is counted as a drop; ts still increments.
//    enable=0 blocks capture and ticks but not draining. ts holds while enable=0.
//    Reset mid-stream: asynchronous, immediate, and nothing is preserved.
// STRUCTURE
//  Shared package spike_stream_pkg holds:
//    WORD_W=16, EVT_FLAG=1'b1, CH_W=4, IDX_W=11, TS_W=15.
//    Function mk_evt(ch, idx) and function mk_tick(ts).
//  One sub-module: sync_fifo_fwft.
//    Parameters WIDTH, DEPTH_LOG2. Ports clk, reset_n, clear, wr_en, din, rd_en, dout, count, empty, full.
//    Behaviour: show-ahead, simultaneous read+write allowed when full.
//  The top level contains capture slots, round-robin-free fixed-priority arbiter, ts counter, drop/underflow logic.
// TESTING
//  T1: reset_n=0 then 1; tick once; pipe_read once -> pipe_dout=16'h0001 (tick, ts=1), then empty=1.
//  T2: NCH=3, index_valid with idx=9'h005, spike_in=3'b101 ->
//      two words in order: 16'h8005 (ch0), then 16'h9005 (ch2), on consecutive cycles; fifo_count=2.
//  T3: tick and index_valid (idx=2, spike_in=3'b010) in the same cycle -> tick word first, then 16'h8802.
//  T4: DEPTH_LOG2=2; push 5 ticks with no reads -> fifo_count=4, full=1, drop_cnt=1.
//      Then pipe_read with a 6th tick in the same cycle -> count stays 4, drop_cnt stays 1.
//  T5: pipe_read with FIFO empty -> underflow=1, pipe_dout=16'h0000, count=0. clear -> underflow=0.
//  T6: fill 3 words, assert reset_n=0 mid-read -> empty=1, drop_cnt=0 immediately, without waiting for clk.
//      32768 ticks after release -> ts wraps; last tick word is 16'h0000.

Source files
------------

// File: rtl/spike_stream_pkg.sv
// Shared word formats and field widths for the spike event streamer.
// Event words carry channel and neuron index; tick words carry the step count.
package spike_stream_pkg;

    localparam int   WORD_W   = 16;
    localparam logic EVT_FLAG = 1'b1;
    localparam int   CH_W     = 4;
    localparam int   IDX_W    = 11;
    localparam int   TS_W     = 15;

    typedef struct packed {
        logic              vld;
        logic [WORD_W-1:0] word;
    } push_t;

    function automatic logic [WORD_W-1:0] mk_evt(
        input logic [CH_W-1:0]  ch,
        input logic [IDX_W-1:0] idx
    );
        return {EVT_FLAG, ch, idx};
    endfunction

    function automatic logic [WORD_W-1:0] mk_tick(
        input logic [TS_W-1:0] ts
    );
        return {~EVT_FLAG, ts};
    endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// Show-ahead synchronous FIFO; head word is visible whenever not empty.
// A read and a write may complete together even when the FIFO is full.
module sync_fifo_fwft #(
    parameter int WIDTH      = 16,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clear,
    input  logic                  wr_en,
    input  logic [WIDTH-1:0]      din,
    input  logic                  rd_en,
    output logic [WIDTH-1:0]      dout,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  empty,
    output logic                  full
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  do_rd, do_wr;

    assign empty = (count_q == '0);
    assign full  = (count_q == (DEPTH_LOG2+1)'(DEPTH));
    assign count = count_q;
    assign dout  = empty ? '0 : mem[rd_ptr_q];

    assign do_rd = rd_en & ~empty;
    assign do_wr = wr_en & (~full | do_rd);

    // Pointer and occupancy next-state
    always_comb begin
        wr_ptr_d = do_wr ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_rd ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        unique case ({do_wr, do_rd})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care until pointers cover them
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/spike_event_streamer.sv
// Captures per-channel spikes and sim-step ticks as 16-bit words
// and streams them through a show-ahead FIFO to a pipe-out reader.
import spike_stream_pkg::*;

module spike_event_streamer #(
    parameter int NCH        = 3,
    parameter int NN         = 8,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clear,
    input  logic                  enable,
    input  logic                  tick,
    input  logic                  index_valid,
    input  logic [NN:0]           neuron_index,
    input  logic [NCH-1:0]        spike_in,
    input  logic                  pipe_read,
    output logic [WORD_W-1:0]     pipe_dout,
    output logic [DEPTH_LOG2:0]   fifo_count,
    output logic                  empty,
    output logic                  full,
    output logic [15:0]           drop_cnt,
    output logic                  underflow
);

    logic [NCH-1:0]   pend_q, pend_d;
    logic [IDX_W-1:0] idx_q [NCH];
    logic [IDX_W-1:0] idx_d [NCH];
    logic             tpend_q, tpend_d;
    logic [TS_W-1:0]  tts_q, tts_d;
    logic [TS_W-1:0]  ts_q, ts_d;
    logic [15:0]      drop_q, drop_d;
    logic             unf_q, unf_d;

    logic             gnt_t;
    logic [NCH-1:0]   gnt_c;
    logic [CH_W-1:0]  sel_ch;
    logic [IDX_W-1:0] sel_idx;
    push_t            push;
    logic             accept, discard;

    logic [NCH-1:0]   cap_v, busy_v, cdrop_v;
    logic             tcap, tbusy;
    logic [4:0]       ndrop;
    logic [16:0]      dsum;

    // Fixed-priority arbiter: pending tick first, then lowest channel
    always_comb begin
        gnt_t   = enable & tpend_q;
        gnt_c   = '0;
        sel_ch  = '0;
        sel_idx = '0;
        if (enable && !tpend_q) begin
            for (int c = NCH - 1; c >= 0; c--) begin
                if (pend_q[c]) begin
                    gnt_c    = '0;
                    gnt_c[c] = 1'b1;
                    sel_ch   = CH_W'(c);
                    sel_idx  = idx_q[c];
                end
            end
        end
        push.vld  = gnt_t | (|gnt_c);
        push.word = gnt_t ? mk_tick(tts_q) : mk_evt(sel_ch, sel_idx);
    end

    // A word offered while full and not being drained is lost
    assign accept  = push.vld & (~full | pipe_read);
    assign discard = push.vld & ~accept;

    // A slot is busy if it stays pending after this cycle's push
    assign cap_v   = {NCH{enable & index_valid}} & spike_in;
    assign busy_v  = pend_q & ~gnt_c;
    assign cdrop_v = cap_v & busy_v;
    assign pend_d  = busy_v | cap_v;
    assign tcap    = enable & tick;
    assign tbusy   = tpend_q & ~gnt_t;

    // Slot, timestamp and drop-counter next-state
    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            idx_d[c] = (cap_v[c] && !busy_v[c])
                     ? IDX_W'(neuron_index) : idx_q[c];
        end
        ts_d    = tcap ? ts_q + TS_W'(1) : ts_q;
        tpend_d = tbusy | tcap;
        tts_d   = (tcap && !tbusy) ? ts_d : tts_q;
        ndrop   = {4'b0, discard};
        for (int c = 0; c < NCH; c++) begin
            ndrop = ndrop + {4'b0, cdrop_v[c]};
        end
        ndrop  = ndrop + {4'b0, tcap & tbusy};
        dsum   = {1'b0, drop_q} + 17'(ndrop);
        drop_d = dsum[16] ? 16'hFFFF : dsum[15:0];
        unf_d  = unf_q | (pipe_read & empty);
    end

    // Capture-side state registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_q  <= '0;
            tpend_q <= 1'b0;
            tts_q   <= '0;
            ts_q    <= '0;
            drop_q  <= '0;
            unf_q   <= 1'b0;
            for (int c = 0; c < NCH; c++) idx_q[c] <= '0;
        end else if (clear) begin
            pend_q  <= '0;
            tpend_q <= 1'b0;
            tts_q   <= '0;
            ts_q    <= '0;
            drop_q  <= '0;
            unf_q   <= 1'b0;
            for (int c = 0; c < NCH; c++) idx_q[c] <= '0;
        end else begin
            pend_q  <= pend_d;
            tpend_q <= tpend_d;
            tts_q   <= tts_d;
            ts_q    <= ts_d;
            drop_q  <= drop_d;
            unf_q   <= unf_d;
            for (int c = 0; c < NCH; c++) idx_q[c] <= idx_d[c];
        end
    end

    sync_fifo_fwft #(
        .WIDTH      (WORD_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (clear),
        .wr_en   (accept),
        .din     (push.word),
        .rd_en   (pipe_read),
        .dout    (pipe_dout),
        .count   (fifo_count),
        .empty   (empty),
        .full    (full)
    );

    assign drop_cnt  = drop_q;
    assign underflow = unf_q;

endmodule

// File: tb/tb_spike_event_streamer.sv
// Directed bench for spike_event_streamer with a queue-based
// reference model checked every cycle plus literal expectations.
module tb_spike_event_streamer;

    localparam int NCH = 3;
    localparam int NN  = 8;
    localparam int DL2 = 2;
    localparam int CAP = 1 << DL2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clear = 1'b0;
    logic          enable = 1'b1;
    logic          tick = 1'b0;
    logic          iv = 1'b0;
    logic [NN:0]   idx = '0;
    logic [NCH-1:0] spk = '0;
    logic          pipe_read = 1'b0;
    logic [15:0]   dout;
    logic [DL2:0]  count;
    logic          empty, full;
    logic [15:0]   drop;
    logic          unf;

    int vectors = 0;
    int miscompares = 0;

    spike_event_streamer #(.NCH(NCH), .NN(NN), .DEPTH_LOG2(DL2)) dut (
        .clk          (clk),
        .reset_n      (rst_n),
        .clear        (clear),
        .enable       (enable),
        .tick         (tick),
        .index_valid  (iv),
        .neuron_index (idx),
        .spike_in     (spk),
        .pipe_read    (pipe_read),
        .pipe_dout    (dout),
        .fifo_count   (count),
        .empty        (empty),
        .full         (full),
        .drop_cnt     (drop),
        .underflow    (unf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // Reference model: queue of words, pending flags, step counter
    logic [15:0] mq [$];
    bit          mpend [NCH];
    logic [10:0] midx [NCH];
    bit          mtp;
    logic [14:0] mtts, mts;
    int          mdrop;
    bit          munf;

    task automatic model_reset();
        mq.delete();
        for (int c = 0; c < NCH; c++) begin
            mpend[c] = 0;
            midx[c]  = '0;
        end
        mtp = 0; mtts = '0; mts = '0; mdrop = 0; munf = 0;
    endtask

    task automatic model_step();
        int drops = 0;
        int gc = -1;
        bit gt = 0;
        bit rd_ok, push_ok;
        logic [3:0] chv;
        logic [15:0] w;
        if (enable) begin
            if (mtp) gt = 1;
            else begin
                for (int c = 0; c < NCH; c++)
                    if (mpend[c] && gc < 0) gc = c;
            end
        end
        rd_ok   = pipe_read && mq.size() > 0;
        push_ok = (mq.size() < CAP) || rd_ok;
        if (pipe_read && mq.size() == 0) munf = 1;
        if (rd_ok) void'(mq.pop_front());
        if (gt || gc >= 0) begin
            if (gt) w = {1'b0, mtts};
            else begin
                chv = gc[3:0];
                w = {1'b1, chv, midx[gc]};
            end
            if (push_ok) mq.push_back(w);
            else drops++;
            if (gt) mtp = 0;
            else mpend[gc] = 0;
        end
        if (enable && iv) begin
            for (int c = 0; c < NCH; c++) begin
                if (spk[c]) begin
                    if (mpend[c]) drops++;
                    else begin
                        mpend[c] = 1;
                        midx[c]  = 11'(idx);
                    end
                end
            end
        end
        if (enable && tick) begin
            mts = mts + 15'd1;
            if (mtp) drops++;
            else begin
                mtp  = 1;
                mtts = mts;
            end
        end
        mdrop = mdrop + drops;
        if (mdrop > 65535) mdrop = 65535;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n || clear) model_reset();
            else model_step();
        end
    end

    // Per-cycle comparison against the model
    initial begin
        forever begin
            @(negedge clk);
            chk("dout",  32'(dout),  32'(mq.size() > 0 ? mq[0] : 16'h0));
            chk("count", 32'(count), 32'(mq.size()));
            chk("empty", 32'(empty), 32'(mq.size() == 0));
            chk("full",  32'(full),  32'(mq.size() == CAP));
            chk("drop",  32'(drop),  32'(mdrop));
            chk("unf",   32'(unf),   32'(munf));
        end
    end

    logic [15:0] dut_last = 16'hDEAD;
    initial begin
        forever begin
            @(posedge clk);
            if (pipe_read && !empty) dut_last <= dout;
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pop1();
        pipe_read = 1'b1;
        cyc();
        pipe_read = 1'b0;
    endtask

    initial begin
        cyc(2);
        rst_n = 1'b1;
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full",  32'(full),  32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_dout",  32'(dout),  32'h0);

        // T1: single tick
        tick = 1'b1; cyc(); tick = 1'b0; cyc();
        chk("t1_dout",  32'(dout),  32'h0001);
        chk("t1_empty", 32'(empty), 32'd0);
        pop1();
        chk("t1_drained", 32'(empty), 32'd1);

        // T2: two channels in one strobe
        idx = 9'h005; spk = 3'b101; iv = 1'b1; cyc();
        iv = 1'b0; spk = '0; cyc();
        chk("t2_head0", 32'(dout),  32'h8005);
        chk("t2_cnt1",  32'(count), 32'd1);
        cyc();
        chk("t2_cnt2",  32'(count), 32'd2);
        pop1();
        chk("t2_head1", 32'(dout),  32'h9005);
        pop1();
        chk("t2_empty", 32'(empty), 32'd1);

        // T3: tick and spike together
        tick = 1'b1; iv = 1'b1; idx = 9'h002; spk = 3'b010; cyc();
        tick = 1'b0; iv = 1'b0; spk = '0; cyc(2);
        chk("t3_cnt",   32'(count), 32'd2);
        chk("t3_tick",  32'(dout),  32'h0002);
        pop1();
        chk("t3_evt",   32'(dout),  32'h8802);
        pop1();

        // T4: overfill with ticks, then read+tick while full
        tick = 1'b1; cyc(5); tick = 1'b0; cyc(2);
        chk("t4_cnt",  32'(count), 32'd4);
        chk("t4_full", 32'(full),  32'd1);
        chk("t4_drop", 32'(drop),  32'd1);
        tick = 1'b1; pipe_read = 1'b1; cyc();
        tick = 1'b0; pipe_read = 1'b0; cyc();
        chk("t4_cnt2",  32'(count), 32'd4);
        chk("t4_drop2", 32'(drop),  32'd1);
        chk("t4_head",  32'(dout),  32'h0004);
        repeat (4) pop1();
        chk("t4_empty", 32'(empty), 32'd1);

        // T5: underflow and clear
        pop1();
        chk("t5_unf",  32'(unf),   32'd1);
        chk("t5_dout", 32'(dout),  32'h0);
        chk("t5_cnt",  32'(count), 32'd0);
        clear = 1'b1; cyc(); clear = 1'b0;
        chk("t5_unf_clr",  32'(unf),  32'd0);
        chk("t5_drop_clr", 32'(drop), 32'd0);

        // T6: three words plus one drop, then async reset mid-read
        tick = 1'b1; iv = 1'b1; idx = 9'h003; spk = 3'b001; cyc();
        tick = 1'b0; idx = 9'h004; cyc();
        iv = 1'b0; spk = '0; tick = 1'b1; cyc();
        tick = 1'b0; cyc();
        chk("t6_cnt",  32'(count), 32'd3);
        chk("t6_drop", 32'(drop),  32'd1);
        chk("t6_head", 32'(dout),  32'h0001);
        pipe_read = 1'b1; cyc();
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_empty", 32'(empty), 32'd1);
        chk("t6_rst_drop",  32'(drop),  32'd0);
        chk("t6_rst_cnt",   32'(count), 32'd0);
        chk("t6_rst_dout",  32'(dout),  32'h0);
        cyc(2);
        pipe_read = 1'b0;
        rst_n = 1'b1;

        // Timestamp wrap over a full 2^15 ticks with continuous draining
        repeat (32768) begin
            tick = 1'b1; pipe_read = 1'b1; cyc();
        end
        tick = 1'b0;
        cyc(6);
        pipe_read = 1'b0;
        chk("wrap_last",  32'(dut_last), 32'h0000);
        chk("wrap_empty", 32'(empty),    32'd1);
        chk("wrap_drop",  32'(drop),     32'd0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
